// File: rtl/counter_stream_checker.sv
// Receive-side checker for a free-running count stream: locks onto an incrementing
// sequence, counts and flags mismatches while locked, and pulses on wrap-around.
module counter_stream_checker #(
    parameter int WIDTH      = 8,
    parameter int LOCK_COUNT = 4,
    parameter int LOSS_COUNT = 3,
    parameter int ERR_WIDTH  = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 sample_en,
    input  logic [WIDTH-1:0]     data_in,
    input  logic                 clear,
    output logic                 locked,
    output logic                 err_pulse,
    output logic                 wrap_pulse,
    output logic [ERR_WIDTH-1:0] err_count,
    output logic [WIDTH-1:0]     expected
);

    localparam int GW = $clog2(LOCK_COUNT + 1);
    localparam int BW = $clog2(LOSS_COUNT + 1);

    typedef enum logic [1:0] {
        S_SEARCH  = 2'd0,
        S_ACQUIRE = 2'd1,
        S_LOCKED  = 2'd2
    } state_t;

    state_t               r_state;
    logic [WIDTH-1:0]     r_expected;
    logic [GW-1:0]        r_good_cnt;
    logic [BW-1:0]        r_bad_cnt;
    logic [ERR_WIDTH-1:0] r_err_count;
    logic                 r_err_pulse;
    logic                 r_wrap_pulse;

    state_t               w_next_state;
    logic [WIDTH-1:0]     w_next_expected;
    logic [GW-1:0]        w_next_good_cnt;
    logic [BW-1:0]        w_next_bad_cnt;
    logic [ERR_WIDTH-1:0] w_next_err_count;
    logic                 w_err;
    logic                 w_wrap;
    logic                 w_match;
    logic [WIDTH-1:0]     w_data_inc;
    logic [GW-1:0]        w_good_inc;
    logic [BW-1:0]        w_bad_inc;

    assign w_match    = (data_in == r_expected);
    assign w_data_inc = data_in + WIDTH'(1);
    assign w_good_inc = r_good_cnt + GW'(1);
    assign w_bad_inc  = r_bad_cnt + BW'(1);

    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        w_next_state    = r_state;
        w_next_expected = r_expected;
        w_next_good_cnt = r_good_cnt;
        w_next_bad_cnt  = r_bad_cnt;
        w_err           = 1'b0;
        w_wrap          = 1'b0;

        case (r_state)
            S_SEARCH: begin
                if (sample_en) begin
                    w_next_expected = w_data_inc;
                    w_next_good_cnt = GW'(1);
                    w_next_state    = S_ACQUIRE;
                end
            end
            S_ACQUIRE: begin
                if (sample_en) begin
                    w_next_expected = w_data_inc;
                    if (w_match) begin
                        w_next_good_cnt = w_good_inc;
                        if (w_good_inc == GW'(LOCK_COUNT)) begin
                            w_next_state   = S_LOCKED;
                            w_next_bad_cnt = '0;
                        end
                    end else begin
                        w_next_good_cnt = GW'(1);
                    end
                end
            end
            S_LOCKED: begin
                if (sample_en) begin
                    // Flywheel: keep counting from our own expectation, not the stream.
                    w_next_expected = r_expected + WIDTH'(1);
                    if (w_match) begin
                        w_next_bad_cnt = '0;
                        w_wrap         = (data_in == '0);
                    end else begin
                        w_err          = 1'b1;
                        w_next_bad_cnt = w_bad_inc;
                        if (w_bad_inc == BW'(LOSS_COUNT)) begin
                            w_next_state    = S_ACQUIRE;
                            w_next_expected = w_data_inc;
                            w_next_good_cnt = GW'(1);
                            w_next_bad_cnt  = '0;
                        end
                    end
                end
            end
            default: w_next_state = S_SEARCH;
        endcase

        // A clear in the same cycle as a counted error wins over the increment.
        w_next_err_count = r_err_count;
        if (clear) begin
            w_next_err_count = '0;
        end else if (w_err && (r_err_count != {ERR_WIDTH{1'b1}})) begin
            w_next_err_count = r_err_count + ERR_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_SEARCH;
            r_expected   <= '0;
            r_good_cnt   <= '0;
            r_bad_cnt    <= '0;
            r_err_count  <= '0;
            r_err_pulse  <= 1'b0;
            r_wrap_pulse <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together.
            r_state      <= w_next_state;
            r_expected   <= w_next_expected;
            r_good_cnt   <= w_next_good_cnt;
            r_bad_cnt    <= w_next_bad_cnt;
            r_err_count  <= w_next_err_count;
            r_err_pulse  <= w_err;
            r_wrap_pulse <= w_wrap;
        end
    end

    assign locked     = (r_state == S_LOCKED);
    assign err_pulse  = r_err_pulse;
    assign wrap_pulse = r_wrap_pulse;
    assign err_count  = r_err_count;
    assign expected   = r_expected;

endmodule

// File: tb/tb_counter_stream_checker.sv
// Directed, table-driven bench for counter_stream_checker: default-parameter instance
// for lock/wrap/flywheel/loss cases, ERR_WIDTH=2 instance for saturation, clear and reset.
module tb_counter_stream_checker;

    logic       clk;
    logic       rst_n;
    logic       sample_en;
    logic [7:0] data_in;
    logic       clear;

    logic       a_locked, a_err, a_wrap;
    logic [7:0] a_cnt, a_exp;
    logic       b_locked, b_err, b_wrap;
    logic [1:0] b_cnt;
    logic [7:0] b_exp;

    int checks   = 0;
    int failures = 0;

    counter_stream_checker u_dut_a (
        .clk(clk), .rst_n(rst_n), .sample_en(sample_en), .data_in(data_in), .clear(clear),
        .locked(a_locked), .err_pulse(a_err), .wrap_pulse(a_wrap),
        .err_count(a_cnt), .expected(a_exp)
    );

    counter_stream_checker #(.ERR_WIDTH(2)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .sample_en(sample_en), .data_in(data_in), .clear(clear),
        .locked(b_locked), .err_pulse(b_err), .wrap_pulse(b_wrap),
        .err_count(b_cnt), .expected(b_exp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit         rst;
        bit         en;
        logic [7:0] data;
        bit         clr;
        bit         e_locked;
        bit         e_err;
        bit         e_wrap;
        logic [7:0] e_cnt;
        logic [7:0] e_exp;
        string      tag;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input bit rst, input bit en, input logic [7:0] data, input bit clr,
                       input bit lk, input bit er, input bit wr,
                       input logic [7:0] cnt, input logic [7:0] ex, input string tag);
        vec_t v;
        v.rst = rst; v.en = en; v.data = data; v.clr = clr;
        v.e_locked = lk; v.e_err = er; v.e_wrap = wr; v.e_cnt = cnt; v.e_exp = ex; v.tag = tag;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n     = 1'b0;
        sample_en = 1'b0;
        clear     = 1'b0;
        data_in   = '0;
        @(negedge clk);
        rst_n = 1'b1;
        check("reset_a", {a_locked, a_err, a_wrap, a_cnt, a_exp}, '0);
    endtask

    task automatic step(input bit en, input logic [7:0] data, input bit clr);
        @(negedge clk);
        sample_en = en;
        data_in   = data;
        clear     = clr;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b1; sample_en = 1'b0; data_in = '0; clear = 1'b0;

        // rst en data clr | locked err wrap cnt exp
        // 1: clean lock from 0
        add(1,1,  0,0, 0,0,0,0,  1,"t1_s0");
        add(0,1,  1,0, 0,0,0,0,  2,"t1_s1");
        add(0,1,  2,0, 0,0,0,0,  3,"t1_s2");
        add(0,1,  3,0, 1,0,0,0,  4,"t1_s3");
        add(0,1,  4,0, 1,0,0,0,  5,"t1_s4");
        add(0,1,  5,0, 1,0,0,0,  6,"t1_s5");
        add(0,1,  6,0, 1,0,0,0,  7,"t1_s6");
        add(0,1,  7,0, 1,0,0,0,  8,"t1_s7");
        add(0,1,  8,0, 1,0,0,0,  9,"t1_s8");
        add(0,1,  9,0, 1,0,0,0, 10,"t1_s9");
        // 2: wrap 255 -> 0
        add(1,1,250,0, 0,0,0,0,251,"t2_250");
        add(0,1,251,0, 0,0,0,0,252,"t2_251");
        add(0,1,252,0, 0,0,0,0,253,"t2_252");
        add(0,1,253,0, 1,0,0,0,254,"t2_253");
        add(0,1,254,0, 1,0,0,0,255,"t2_254");
        add(0,1,255,0, 1,0,0,0,  0,"t2_255");
        add(0,1,  0,0, 1,0,1,0,  1,"t2_0");
        add(0,1,  1,0, 1,0,0,0,  2,"t2_1");
        // 3: single glitch, flywheel keeps lock
        add(1,1, 18,0, 0,0,0,0, 19,"t3_18");
        add(0,1, 19,0, 0,0,0,0, 20,"t3_19");
        add(0,1, 20,0, 0,0,0,0, 21,"t3_20");
        add(0,1, 21,0, 1,0,0,0, 22,"t3_21");
        add(0,1, 99,0, 1,1,0,1, 23,"t3_99");
        add(0,1, 23,0, 1,0,0,1, 24,"t3_23");
        add(0,1, 24,0, 1,0,0,1, 25,"t3_24");
        // 4: source restart while locked at expected=50
        add(1,1, 46,0, 0,0,0,0, 47,"t4_46");
        add(0,1, 47,0, 0,0,0,0, 48,"t4_47");
        add(0,1, 48,0, 0,0,0,0, 49,"t4_48");
        add(0,1, 49,0, 1,0,0,0, 50,"t4_49");
        add(0,1,  0,0, 1,1,0,1, 51,"t4_0");
        add(0,1,  1,0, 1,1,0,2, 52,"t4_1");
        add(0,1,  2,0, 0,1,0,3,  3,"t4_2");
        add(0,1,  3,0, 0,0,0,3,  4,"t4_3");
        add(0,1,  4,0, 0,0,0,3,  5,"t4_4");
        add(0,1,  5,0, 1,0,0,3,  6,"t4_5");
        // 5: sample_en gaps with junk data are ignored
        add(1,1,  5,0, 0,0,0,0,  6,"t5_5");
        add(0,1,  6,0, 0,0,0,0,  7,"t5_6");
        add(0,0,170,0, 0,0,0,0,  7,"t5_gap0");
        add(0,0,170,0, 0,0,0,0,  7,"t5_gap1");
        add(0,1,  7,0, 0,0,0,0,  8,"t5_7");
        add(0,1,  8,0, 1,0,0,0,  9,"t5_8");
        // clear alone zeroes the count; locked and expected unaffected
        add(1,1, 30,0, 0,0,0,0, 31,"tc_30");
        add(0,1, 31,0, 0,0,0,0, 32,"tc_31");
        add(0,1, 32,0, 0,0,0,0, 33,"tc_32");
        add(0,1, 33,0, 1,0,0,0, 34,"tc_33");
        add(0,1,200,0, 1,1,0,1, 35,"tc_err");
        add(0,1, 35,1, 1,0,0,0, 36,"tc_clr");

        foreach (vecs[i]) begin
            if (vecs[i].rst) do_reset();
            step(vecs[i].en, vecs[i].data, vecs[i].clr);
            check({vecs[i].tag, "_locked"}, 32'(a_locked), 32'(vecs[i].e_locked));
            check({vecs[i].tag, "_err"},    32'(a_err),    32'(vecs[i].e_err));
            check({vecs[i].tag, "_wrap"},   32'(a_wrap),   32'(vecs[i].e_wrap));
            check({vecs[i].tag, "_cnt"},    32'(a_cnt),    32'(vecs[i].e_cnt));
            check({vecs[i].tag, "_exp"},    32'(a_exp),    32'(vecs[i].e_exp));
        end

        // 6: ERR_WIDTH=2 saturation, then clear racing a mismatch, then async reset
        do_reset();
        for (int i = 0; i < 4; i++) step(1'b1, 8'(i), 1'b0);
        check("t6_lock", {31'd0, b_locked}, 32'd1);
        begin
            logic [1:0] want;
            logic [7:0] nxt;
            want = 2'd0;
            nxt  = 8'd4;
            for (int k = 0; k < 6; k++) begin
                step(1'b1, 8'd100, 1'b0);
                if (want != 2'd3) want = want + 2'd1;
                nxt = nxt + 8'd1;
                check("t6_sat_err",  32'(b_err), 32'd1);
                check("t6_sat_cnt",  32'(b_cnt), 32'(want));
                step(1'b1, nxt, 1'b0);
                nxt = nxt + 8'd1;
                check("t6_sat_lock", 32'(b_locked), 32'd1);
            end
            check("t6_sat_final", 32'(b_cnt), 32'd3);
            check("t6_exp", 32'(b_exp), 32'd16);
        end
        step(1'b1, 8'd100, 1'b1);
        check("t6_clr_cnt", 32'(b_cnt), 32'd0);
        check("t6_clr_err", 32'(b_err), 32'd1);
        check("t6_clr_exp", 32'(b_exp), 32'd17);

        step(1'b1, 8'd17, 1'b0);
        check("t6_pre_rst_locked", 32'(b_locked), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_async_rst_b", {b_locked, b_err, b_wrap, b_cnt, b_exp}, '0);
        check("t6_async_rst_a", {a_locked, a_err, a_wrap, a_cnt, a_exp}, '0);
        @(negedge clk);
        sample_en = 1'b0;
        rst_n     = 1'b1;
        step(1'b1, 8'd40, 1'b0);
        check("t6_resume_exp", 32'(b_exp), 32'd41);
        check("t6_resume_locked", 32'(b_locked), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/counter_stream_checker.md
Name: counter_stream_checker

Overview:
- Receive-side companion to the free-running 8-bit pin counter: samples an incoming count stream and checks that each valid sample equals the previous one plus 1, modulo 2^WIDTH.
- Locks onto the sequence, counts sequence errors once locked, flags wrap-around, and drops lock on persistent mismatch.
- Sits on the input pins of a tile that reads another tile's counter output, and feeds status to the outputs or debug logic.

Parameters:
- WIDTH, 8, width of the sampled count.
- LOCK_COUNT, 4, consecutive in-sequence samples (seed included) needed to assert lock; legal range >= 2.
- LOSS_COUNT, 3, consecutive mismatches while locked that drop lock; legal range >= 1.
- ERR_WIDTH, 8, width of the saturating error counter.

Ports:
- clk  input  1  clock.
- rst_n  input  1  reset, asynchronous, active-low.
- sample_en  input  1  data_in is valid this cycle.
- data_in  input  WIDTH  sampled count value.
- clear  input  1  synchronous clear of err_count.
- locked  output  1  high while in LOCKED.
- err_pulse  output  1  one-cycle pulse per mismatch counted in LOCKED.
- wrap_pulse  output  1  one-cycle pulse when a matching sample equal to 0 is seen in LOCKED.
- err_count  output  ERR_WIDTH  saturating mismatch count.
- expected  output  WIDTH  next value the checker expects.

Behaviour:
- Reset (async, rst_n=0):
  - State SEARCH.
  - locked, err_pulse, wrap_pulse = 0.
  - err_count = 0, expected = 0.
  - Internal good_cnt and bad_cnt = 0.
- All outputs are registered. A sample taken at edge N is reflected in the outputs immediately after edge N; there is no further pipeline delay.
- When sample_en=0:
  - State, expected, good_cnt and bad_cnt hold.
  - err_pulse and wrap_pulse are 0.
  - data_in is ignored.
- SEARCH, on a valid sample: expected <= data_in+1, good_cnt <= 1, go to ACQUIRE.
- ACQUIRE, on a valid sample:
  - Match (data_in==expected): expected <= data_in+1, good_cnt <= good_cnt+1.
  - If the new good_cnt equals LOCK_COUNT, go to LOCKED, set locked=1, bad_cnt <= 0.
  - Mismatch: reseed with expected <= data_in+1 and good_cnt <= 1; stay in ACQUIRE.
  - No errors are counted outside LOCKED.
- LOCKED, on a valid sample:
  - Match: expected <= expected+1, bad_cnt <= 0. If data_in==0, wrap_pulse=1.
  - Mismatch:
    - Flywheel: expected <= expected+1, not resynced.
    - err_pulse=1, err_count increments with saturation, bad_cnt <= bad_cnt+1.
    - If the new bad_cnt equals LOSS_COUNT: go to ACQUIRE, locked=0, expected <= data_in+1, good_cnt <= 1. This error is still counted.
- Arithmetic:
  - All expected updates wrap modulo 2^WIDTH, so 255+1 = 0 at WIDTH=8.
  - err_count saturates at 2^ERR_WIDTH-1 and never wraps.
- clear:
  - Sets err_count to 0 on the next edge and affects nothing else.
  - If clear coincides with a counted error, clear wins: err_count = 0, and err_pulse still fires.
- Reset mid-stream: asserting rst_n returns everything to reset values immediately. Deasserting it resumes in SEARCH.
- State encoding is implementer's choice. Unused encodings recover to SEARCH.

Test Plan:
1. Reset, then sample_en=1 with data 0,1,2,...,9 on consecutive cycles -> locked rises after the edge sampling 3. err_count stays 0 and expected reads 10 after sample 9.
2. Lock on 250..255, then 0,1 -> wrap_pulse high exactly one cycle, after the edge sampling 0; locked stays 1; err_count 0.
3. Locked at 20,21, inject 99, then 23,24 -> a single err_pulse after the 99 edge, err_count=1, locked stays 1, and no further errors on 23,24 (flywheel).
4. Locked with expected=50, source restarts with 0,1,2,3,4,5:
   - Mismatches on 0, 1 and 2 give err_count=3.
   - locked falls after the edge sampling 2, with expected reseeded to 3.
   - locked rises again after the edge sampling 5.
5. Stream 5,6, then two cycles with sample_en=0 and data_in=0xAA, then 7,8 -> no err_pulse; good_cnt progression is unaffected and locked asserts on schedule.
6. ERR_WIDTH=2, locked, six mismatches spaced by matches -> err_count sticks at 3. Then:
   - clear together with a mismatch -> err_count=0 and err_pulse=1.
   - rst_n low mid-stream -> all outputs 0 without waiting for a clock edge.
